// File: rtl/branch_sequencer.sv
// Fetch-side PC controller: predict-not-taken sequencing, EX branch redirect,
// ID jumps, stall/halt handling and saturating branch statistics.
module branch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             jump_valid,
    input  logic [31:0]      jump_target,
    input  logic             ex_branch_valid,
    input  logic             ex_branch_taken,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_branch_offset,
    output logic [31:0]      if_pc,
    output logic             if_valid,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {BOOT, RUN, REDIRECT, HALTED} state_t;

    state_t            r_state, w_state_nxt;
    logic [31:0]       r_pc, w_pc_nxt;
    logic              r_misalign, w_mis_set;
    logic              w_flush_if_id, w_flush_id_ex;
    logic              w_taken, w_cnt_en;
    logic [CNT_W-1:0]  r_branch_cnt, r_taken_cnt;

    assign w_taken  = ex_branch_valid & ex_branch_taken;
    assign w_cnt_en = (r_state == RUN) & ex_branch_valid;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_mis_set     = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        case (r_state)
            BOOT:     w_state_nxt = RUN;
            RUN: begin
                // A taken branch kills everything younger, including any jump/halt/stall.
                if (w_taken) begin
                    w_flush_if_id = 1'b1;
                    w_flush_id_ex = 1'b1;
                    w_pc_nxt      = ex_pc + 32'd4 + ex_branch_offset;
                    w_state_nxt   = REDIRECT;
                end else if (jump_valid) begin
                    w_flush_if_id = 1'b1;
                    w_pc_nxt      = {jump_target[31:2], 2'b00};
                    w_mis_set     = (jump_target[1:0] != 2'b00);
                    w_state_nxt   = REDIRECT;
                end else if (halt_req) begin
                    w_state_nxt   = HALTED;
                end else if (!stall) begin
                    w_pc_nxt      = r_pc + 32'd4;
                end
            end
            REDIRECT: w_state_nxt = RUN;
            HALTED:   w_state_nxt = HALTED;
            default:  w_state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_misalign   <= 1'b0;
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_mis_set)
                r_misalign <= 1'b1;
            if (w_cnt_en && (r_branch_cnt != {CNT_W{1'b1}}))
                r_branch_cnt <= r_branch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_cnt_en && ex_branch_taken && (r_taken_cnt != {CNT_W{1'b1}}))
                r_taken_cnt <= r_taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign if_pc        = r_pc;
    assign if_valid     = (r_state == RUN);
    assign halted       = (r_state == HALTED);
    assign flush_if_id  = w_flush_if_id;
    assign flush_id_ex  = w_flush_id_ex;
    assign misalign_err = r_misalign;
    assign branch_count = r_branch_cnt;
    assign taken_count  = r_taken_cnt;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: expected outputs are queued when each
// step is driven and popped against the DUT mid-cycle.
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, halt_req, jump_valid;
    logic [31:0] jump_target;
    logic        ex_branch_valid, ex_branch_taken;
    logic [31:0] ex_pc, ex_branch_offset;
    logic [31:0] if_pc;
    logic        if_valid, flush_if_id, flush_id_ex, halted, misalign_err;
    logic [15:0] branch_count, taken_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic        v, fif, fie, h, m;
        logic [15:0] bc, tc;
    } exp_t;

    exp_t sb[$];

    branch_sequencer #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .halt_req(halt_req),
        .jump_valid(jump_valid), .jump_target(jump_target),
        .ex_branch_valid(ex_branch_valid), .ex_branch_taken(ex_branch_taken),
        .ex_pc(ex_pc), .ex_branch_offset(ex_branch_offset),
        .if_pc(if_pc), .if_valid(if_valid), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .halted(halted), .misalign_err(misalign_err),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic v, input logic fif, input logic fie,
                        input logic h, input logic m, input logic [15:0] bc, input logic [15:0] tc);
        exp_t e;
        e.pc = pc; e.v = v; e.fif = fif; e.fie = fie; e.h = h; e.m = m; e.bc = bc; e.tc = tc;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            cmp({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        cmp({tag, "_pc"},   if_pc,                e.pc);
        cmp({tag, "_vld"},  {31'd0, if_valid},    {31'd0, e.v});
        cmp({tag, "_fif"},  {31'd0, flush_if_id}, {31'd0, e.fif});
        cmp({tag, "_fie"},  {31'd0, flush_id_ex}, {31'd0, e.fie});
        cmp({tag, "_hlt"},  {31'd0, halted},      {31'd0, e.h});
        cmp({tag, "_mis"},  {31'd0, misalign_err},{31'd0, e.m});
        cmp({tag, "_bc"},   {16'd0, branch_count},{16'd0, e.bc});
        cmp({tag, "_tc"},   {16'd0, taken_count}, {16'd0, e.tc});
    endtask

    // Inputs were set at the preceding negedge; check mid-cycle, then advance.
    task automatic step(input string tag, input logic [31:0] pc, input logic v, input logic fif,
                        input logic fie, input logic h, input logic m,
                        input logic [15:0] bc, input logic [15:0] tc);
        push(pc, v, fif, fie, h, m, bc, tc);
        #2;
        pop_check(tag);
        @(negedge clk);
    endtask

    task automatic idle();
        stall = 0; halt_req = 0; jump_valid = 0; jump_target = 0;
        ex_branch_valid = 0; ex_branch_taken = 0; ex_pc = 0; ex_branch_offset = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        push(32'h0, 0, 0, 0, 0, 0, 16'd0, 16'd0);
        #2 pop_check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Boot bubble then sequential fetch
        step("boot",  32'h0, 0, 0, 0, 0, 0, 0, 0);
        step("run0",  32'h0, 1, 0, 0, 0, 0, 0, 0);
        step("run4",  32'h4, 1, 0, 0, 0, 0, 0, 0);
        step("run8",  32'h8, 1, 0, 0, 0, 0, 0, 0);
        step("runC",  32'hC, 1, 0, 0, 0, 0, 0, 0);

        // Taken backward branch: 0x40 + 4 - 0x10 = 0x34
        ex_branch_valid = 1; ex_branch_taken = 1; ex_pc = 32'h40; ex_branch_offset = 32'hFFFF_FFF0;
        step("beq",   32'h10, 1, 1, 1, 0, 0, 0, 0);
        idle();
        step("redir1", 32'h34, 0, 0, 0, 0, 0, 1, 1);
        step("tgt34",  32'h34, 1, 0, 0, 0, 0, 1, 1);
        step("tgt38",  32'h38, 1, 0, 0, 0, 0, 1, 1);

        // Branch overrides jump, stall and halt in the same cycle
        ex_branch_valid = 1; ex_branch_taken = 1; ex_pc = 32'h10; ex_branch_offset = 32'h20;
        jump_valid = 1; jump_target = 32'h100; stall = 1; halt_req = 1;
        step("prio",   32'h3C, 1, 1, 1, 0, 0, 1, 1);
        idle();
        step("redir2", 32'h34, 0, 0, 0, 0, 0, 2, 2);
        step("prio34", 32'h34, 1, 0, 0, 0, 0, 2, 2);

        // Misaligned jump: aligned target, sticky error, only IF/ID flushed
        jump_valid = 1; jump_target = 32'h0000_0203;
        step("jmis",   32'h38, 1, 1, 0, 0, 0, 2, 2);
        idle();
        step("redir3", 32'h200, 0, 0, 0, 0, 1, 2, 2);
        step("j200",   32'h200, 1, 0, 0, 0, 1, 2, 2);
        step("j204",   32'h204, 1, 0, 0, 0, 1, 2, 2);

        // Jump to 0x20, then stall three cycles (one with a not-taken branch)
        jump_valid = 1; jump_target = 32'h20;
        step("j20",    32'h208, 1, 1, 0, 0, 1, 2, 2);
        idle();
        step("redir4", 32'h20, 0, 0, 0, 0, 1, 2, 2);
        stall = 1;
        step("stall1", 32'h20, 1, 0, 0, 0, 1, 2, 2);
        ex_branch_valid = 1;
        step("stall2", 32'h20, 1, 0, 0, 0, 1, 2, 2);
        ex_branch_valid = 0;
        step("stall3", 32'h20, 1, 0, 0, 0, 1, 3, 2);

        // Halt, then a taken branch must be ignored
        idle(); halt_req = 1;
        step("halt",   32'h20, 1, 0, 0, 0, 1, 3, 2);
        idle();
        step("hlt1",   32'h20, 0, 0, 0, 1, 1, 3, 2);
        ex_branch_valid = 1; ex_branch_taken = 1; ex_pc = 32'h80; ex_branch_offset = 32'h40;
        step("hltbr",  32'h20, 0, 0, 0, 1, 1, 3, 2);
        idle();
        step("hlt2",   32'h20, 0, 0, 0, 1, 1, 3, 2);

        // Reset clears halt and sticky misalign
        rst_n = 0;
        #1;
        push(32'h0, 0, 0, 0, 0, 0, 0, 0);
        pop_check("rst2");
        @(negedge clk);
        rst_n = 1;
        step("boot2",  32'h0, 0, 0, 0, 0, 0, 0, 0);

        // Counter saturation: 2^16 + 5 not-taken branches under stall
        stall = 1; ex_branch_valid = 1;
        repeat (65541) @(negedge clk);
        idle();
        step("sat",    32'h0, 1, 0, 0, 0, 0, 16'hFFFF, 16'd0);

        // Taken branch into REDIRECT, then async reset mid-cycle
        ex_branch_valid = 1; ex_branch_taken = 1; ex_pc = 32'h0; ex_branch_offset = 32'h100;
        step("satbr",  32'h4, 1, 1, 1, 0, 0, 16'hFFFF, 16'd0);
        idle();
        push(32'h104, 0, 0, 0, 0, 0, 16'hFFFF, 16'd1);
        #2 pop_check("redir5");
        rst_n = 0;
        #1;
        push(32'h0, 0, 0, 0, 0, 0, 0, 0);
        pop_check("rst3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
